// File: rtl/boid_sched_pkg.sv
// Shared types for the boid frame scheduler: FSM states, read-tag kinds and the
// tag record that travels alongside each memory read.
package boid_sched_pkg;

    localparam int WB_STAGES = 7;

    typedef enum logic [2:0] {
        IDLE,
        SELF_RD,
        ITER,
        DRAIN,
        WB,
        WRITE,
        DONE
    } sched_state_t;

    typedef enum logic {
        SELF,
        NBR
    } rd_kind_t;

    typedef struct packed {
        logic     valid;
        rd_kind_t kind;
    } rd_tag_t;

endpackage

// File: rtl/boid_frame_sched_rd_tag_pipe.sv
// RD_LAT-deep delay line that tells the datapath what the returning read data is.
// It always advances, so tags drain even while the memory port is stalled.
module rd_tag_pipe
    import boid_sched_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    clr,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stages [RD_LAT];

    // NOTE: this is a handful of flops, not a RAM, so clearing every stage is cheap
    // and keeps stale tags from strobing the datapath after an aborted frame.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < RD_LAT; s++) begin
                stages[s] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int s = 1; s < RD_LAT; s++) begin
                stages[s] <= stages[s-1];
            end
        end
    end

    assign tag_out = stages[RD_LAT-1];

endmodule

// File: rtl/boid_frame_sched.sv
// Frame sequencer for the boid datapath: self read, neighbour sweep, writeback, store.
// Define BOID_SCHED_PERF_EN to add the frame_cycles / stall_cycles counters.
module boid_frame_sched
    import boid_sched_pkg::*;
#(
    parameter int N_BOIDS = 2,
    parameter int RD_LAT  = 1,
    parameter int IDX_W   = $clog2(N_BOIDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     which_boid,
    output logic                 mem_rd_en,
    output logic [IDX_W-1:0]     mem_rd_addr,
    output logic                 mem_wr_en,
    output logic                 r_en_tot,
    output logic                 r_en_itr,
    output logic                 acc_clr,
    output logic [WB_STAGES-1:0] wb_en
`ifdef BOID_SCHED_PERF_EN
    ,
    output logic [31:0]          frame_cycles,
    output logic [31:0]          stall_cycles
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BOIDS - 1);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [2:0]       cnt_q, cnt_d;
    rd_tag_t          tag_in, tag_out;

    logic [IDX_W-1:0] last_j;
    logic [IDX_W-1:0] j_inc;
    logic [IDX_W-1:0] j_step;

    // The neighbour sweep never visits i, so the final j drops by one for the last boid.
    assign last_j = (i_q == LAST_IDX) ? IDX_W'(N_BOIDS - 2) : LAST_IDX;
    assign j_inc  = j_q + IDX_W'(1);
    assign j_step = (j_inc == i_q) ? j_inc + IDX_W'(1) : j_inc;

    // NOTE: every output and next-state value gets a default before the case,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        cnt_d       = cnt_q;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        acc_clr     = 1'b0;
        wb_en       = '0;
        done        = 1'b0;
        tag_in      = '{valid: 1'b0, kind: SELF};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SELF_RD;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            SELF_RD: begin
                if (!stall) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = i_q;
                    acc_clr     = 1'b1;
                    tag_in      = '{valid: 1'b1, kind: SELF};
                    j_d         = (i_q == '0) ? IDX_W'(1) : '0;
                    state_d     = ITER;
                end
            end
            ITER: begin
                if (!stall) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = j_q;
                    tag_in      = '{valid: 1'b1, kind: NBR};
                    if (j_q == last_j) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        j_d = j_step;
                    end
                end
            end
            DRAIN: begin
                // The last neighbour tag reaches the pipe output on the final drain cycle.
                if (cnt_q == 3'(RD_LAT - 1)) begin
                    state_d = WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WB: begin
                wb_en = WB_STAGES'(1) << cnt_q;
                if (cnt_q == 3'(WB_STAGES - 1)) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WRITE: begin
                if (!stall) begin
                    mem_wr_en = 1'b1;
                    if (i_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + IDX_W'(1);
                        state_d = SELF_RD;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle aborts the frame without touching memory or the datapath.
        if (reset) begin
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
            acc_clr   = 1'b0;
            wb_en     = '0;
            done      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .clr     (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign r_en_tot   = tag_out.valid && (tag_out.kind == SELF);
    assign r_en_itr   = tag_out.valid && (tag_out.kind == NBR);
    assign busy       = (state_q != IDLE);
    assign which_boid = i_q;

`ifdef BOID_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || (state_q == IDLE && start)) begin
            frame_cycles <= '0;
            stall_cycles <= '0;
        end else if (busy) begin
            if (frame_cycles != '1) begin
                frame_cycles <= frame_cycles + 32'd1;
            end
            if (stall && (state_q inside {SELF_RD, ITER, WRITE}) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_boid_frame_sched.sv
// Directed bench for boid_frame_sched: a 4-boid/RD_LAT=2 instance carries most scenarios,
// a 2-boid/RD_LAT=1 instance checks the minimal frame.
module tb_boid_frame_sched;

    logic clk = 1'b0;
    logic reset, start, start2, stall;

    logic       d1_busy, d1_done, d1_rd_en, d1_wr_en, d1_tot, d1_itr, d1_acc;
    logic [1:0] d1_which, d1_addr;
    logic [6:0] d1_wb;

    logic       d2_busy, d2_done, d2_rd_en, d2_wr_en, d2_tot, d2_itr, d2_acc;
    logic [0:0] d2_which, d2_addr;
    logic [6:0] d2_wb;

    always #5 clk = ~clk;

    boid_frame_sched #(.N_BOIDS(4), .RD_LAT(2)) u_dut (
        .clk (clk), .reset (reset), .start (start), .stall (stall),
        .busy (d1_busy), .done (d1_done), .which_boid (d1_which),
        .mem_rd_en (d1_rd_en), .mem_rd_addr (d1_addr), .mem_wr_en (d1_wr_en),
        .r_en_tot (d1_tot), .r_en_itr (d1_itr), .acc_clr (d1_acc), .wb_en (d1_wb)
    );

    boid_frame_sched #(.N_BOIDS(2), .RD_LAT(1)) u_dut2 (
        .clk (clk), .reset (reset), .start (start2), .stall (1'b0),
        .busy (d2_busy), .done (d2_done), .which_boid (d2_which),
        .mem_rd_en (d2_rd_en), .mem_rd_addr (d2_addr), .mem_wr_en (d2_wr_en),
        .r_en_tot (d2_tot), .r_en_itr (d2_itr), .acc_clr (d2_acc), .wb_en (d2_wb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-run observations; reads are encoded as which_boid*16 + address.
    int d1_rd[$];
    int d1_wr[$];
    int d2_rd[$];
    int d2_wr[$];
    int wb3[$];
    int d1_done_at, d1_done_cnt, d2_done_at, d2_done_cnt;
    int d1_tot_cnt, d1_itr_cnt, d2_tot_cnt, d2_itr_cnt;
    int i3_self_cyc, i3_tot_cyc, wb3_first, wb3_last, wr_first_cyc;
    int rd_in_stall, bad_in_stall, viol, rst_snap;

    // Hand-derived read order for 4 boids: self first, then every j != i ascending.
    int exp_rd4 [16] = '{0, 1, 2, 3, 17, 16, 18, 19, 34, 32, 33, 35, 51, 48, 49, 50};

    task automatic run_frame(input int st_lo, input int st_hi, input int rst_at,
                             input int restart_at, input int ncyc, input bit with2);
        d1_rd.delete(); d1_wr.delete(); d2_rd.delete(); d2_wr.delete(); wb3.delete();
        d1_done_at = -1; d1_done_cnt = 0; d2_done_at = -1; d2_done_cnt = 0;
        d1_tot_cnt = 0; d1_itr_cnt = 0; d2_tot_cnt = 0; d2_itr_cnt = 0;
        i3_self_cyc = -1; i3_tot_cyc = -1; wb3_first = -1; wb3_last = -1; wr_first_cyc = -1;
        rd_in_stall = 0; bad_in_stall = 0; viol = 0; rst_snap = -1;
        start  = 1'b1;
        start2 = with2;
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            stall = (c >= st_lo && c < st_hi);
            reset = (c == rst_at);
            start = (c == restart_at);
            @(negedge clk);
            if (d1_rd_en) begin
                d1_rd.push_back(int'(d1_which) * 16 + int'(d1_addr));
                if (d1_which == 2'd3 && d1_acc) i3_self_cyc = c;
            end
            if (d1_wr_en) begin
                d1_wr.push_back(int'(d1_which));
                if (wr_first_cyc < 0) wr_first_cyc = c;
            end
            if (d1_tot) begin
                d1_tot_cnt++;
                if (d1_which == 2'd3) i3_tot_cyc = c;
            end
            if (d1_itr) d1_itr_cnt++;
            if (d1_wb != 7'd0 && d1_which == 2'd3) begin
                if (wb3_first < 0) wb3_first = c;
                wb3_last = c;
                wb3.push_back(int'(d1_wb));
            end
            if (d1_done) begin
                d1_done_cnt++;
                if (d1_done_at < 0) d1_done_at = c;
            end
            if (stall && d1_rd_en) rd_in_stall++;
            if (stall && (d1_wr_en || d1_wb != 7'd0)) bad_in_stall++;
            if ((d1_rd_en && d1_wr_en) || (d1_tot && d1_itr) || !$onehot0(d1_wb)) viol++;
            if ((d2_rd_en && d2_wr_en) || (d2_tot && d2_itr) || !$onehot0(d2_wb)) viol++;
            if (c == rst_at + 1) begin
                rst_snap = int'({d1_busy, d1_done, d1_rd_en, d1_wr_en, d1_tot, d1_itr,
                                 d1_acc, d1_wb, d1_which, d1_addr});
            end
            if (d2_rd_en) d2_rd.push_back(int'(d2_which) * 16 + int'(d2_addr));
            if (d2_wr_en) d2_wr.push_back(int'(d2_which));
            if (d2_tot) d2_tot_cnt++;
            if (d2_itr) d2_itr_cnt++;
            if (d2_done) begin
                d2_done_cnt++;
                if (d2_done_at < 0) d2_done_at = c;
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        reset = 1'b0;
        start = 1'b0;
    endtask

    function automatic int rd4_mismatches();
        int m = 0;
        if (d1_rd.size() != 16) return 99;
        for (int k = 0; k < 16; k++) begin
            if (d1_rd[k] != exp_rd4[k]) m++;
        end
        return m;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(d1_busy), 0);
        check("rst_strobes", int'({d1_done, d1_rd_en, d1_wr_en, d1_tot, d1_itr, d1_acc}), 0);
        check("rst_wb_which", int'({d1_wb, d1_which}), 0);
        check("rst_dut2", int'({d2_busy, d2_done, d2_rd_en, d2_wr_en, d2_tot, d2_itr, d2_wb}), 0);
        @(posedge clk); #1;

        // Nominal frames on both instances.
        run_frame(-1, -1, -1, -1, 70, 1'b1);
        check("n2_done_at", d2_done_at, 23);
        check("n2_done_cnt", d2_done_cnt, 1);
        check("n2_rd_cnt", d2_rd.size(), 4);
        if (d2_rd.size() == 4) begin
            check("n2_rd0", d2_rd[0], 0);
            check("n2_rd1", d2_rd[1], 1);
            check("n2_rd2", d2_rd[2], 17);
            check("n2_rd3", d2_rd[3], 16);
        end
        check("n2_wr_cnt", d2_wr.size(), 2);
        if (d2_wr.size() == 2) begin
            check("n2_wr0", d2_wr[0], 0);
            check("n2_wr1", d2_wr[1], 1);
        end
        check("n2_tot", d2_tot_cnt, 2);
        check("n2_itr", d2_itr_cnt, 2);
        check("n4_done_at", d1_done_at, 57);
        check("n4_rd_seq", rd4_mismatches(), 0);
        check("n4_i3_self", i3_self_cyc, 43);
        check("n4_i3_tot", i3_tot_cyc, 45);
        check("n4_wb_len", wb3.size(), 7);
        for (int k = 0; k < wb3.size() && k < 7; k++) begin
            check($sformatf("n4_wb%0d", k), wb3[k], 1 << k);
        end
        check("n4_wb_first", wb3_first, 49);
        check("n4_wb_last", wb3_last, 55);
        check("n4_wr_cnt", d1_wr.size(), 4);
        check("n4_tot", d1_tot_cnt, 4);
        check("n4_itr", d1_itr_cnt, 12);
        check("excl_a", viol, 0);

        // Five stalled cycles in the middle of boid 0's neighbour sweep.
        run_frame(3, 8, -1, -1, 80, 1'b0);
        check("stl_done_at", d1_done_at, 62);
        check("stl_no_rd", rd_in_stall, 0);
        check("stl_rd_seq", rd4_mismatches(), 0);
        check("stl_itr", d1_itr_cnt, 12);
        check("stl_tot", d1_tot_cnt, 4);

        // A second start while busy must be dropped.
        run_frame(-1, -1, -1, 10, 130, 1'b0);
        check("rs_done_cnt", d1_done_cnt, 1);
        check("rs_done_at", d1_done_at, 57);
        check("rs_rd_cnt", d1_rd.size(), 16);
        check("rs_busy_end", int'(d1_busy), 0);

        // Boid 0's WRITE held off by a three-cycle stall.
        run_frame(14, 17, -1, -1, 80, 1'b0);
        check("ws_wr_first", wr_first_cyc, 17);
        check("ws_hold_quiet", bad_in_stall, 0);
        check("ws_done_at", d1_done_at, 60);
        check("excl_b", viol, 0);

        // Reset during boid 1's writeback, then a clean frame.
        run_frame(-1, -1, 23, -1, 80, 1'b0);
        check("rst_mid_outs", rst_snap, 0);
        check("rst_mid_done", d1_done_cnt, 0);
        check("rst_mid_wr", d1_wr.size(), 1);
        run_frame(-1, -1, -1, -1, 70, 1'b0);
        check("post_rst_done", d1_done_at, 57);
        check("post_rst_rd", rd4_mismatches(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
